// File: rtl/alu_pkg.sv
// Shared ALU/arbiter definitions: opcodes, flag bit positions and arbiter FSM states.
package alu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned FLAG_W = 4;
   localparam int unsigned CNT_W  = 4;

   typedef logic [OP_W-1:0] alu_op_t;

   localparam alu_op_t ALU_ADD = 4'b0000;
   localparam alu_op_t ALU_SUB = 4'b0001;
   localparam alu_op_t ALU_MUL = 4'b0010;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU (add/sub/mul) producing {N,Z,C,V} flags.
module alu
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [OP_W-1:0]   op,
   output logic [DATA_W-1:0] out,
   output logic [FLAG_W-1:0] flags
);

   logic [DATA_W:0]   sum_ext;
   logic [DATA_W-1:0] diff;
   logic              carry;
   logic              ovf;
   logic              unused_clk_rst;

   // Clock and reset are tied at the boundary for uniformity; the datapath is purely combinational.
   assign unused_clk_rst = clk ^ rst;

   always_comb begin
      sum_ext = {1'b0, a} + {1'b0, b};
      diff    = a - b;
      out     = '0;
      ovf     = 1'b0;
      case (op)
         ALU_ADD: begin
            out = sum_ext[DATA_W-1:0];
            ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum_ext[DATA_W-1] != a[DATA_W-1]);
         end
         ALU_SUB: begin
            out = diff;
            ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
         end
         ALU_MUL: out = DATA_W'(a * b);
         default: out = '0;
      endcase
      carry = (op == ALU_ADD) ? sum_ext[DATA_W] : (diff > a);
      flags = '0;
      flags[FLAG_N] = out[DATA_W-1];
      flags[FLAG_Z] = (out == '0);
      flags[FLAG_C] = carry;
      flags[FLAG_V] = ovf;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters, one op in flight.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [3:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [3:0]  req1_op,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_out,
   output logic [3:0]  rsp_flags
);

   arb_state_t        state;
   logic [CNT_W-1:0]  cnt;
   logic              prio;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   alu_op_t           op_q;
   logic              id_q;
   logic              grant;
   logic              accept;
   alu_op_t           sel_op;
   logic [DATA_W-1:0] alu_out;
   logic [FLAG_W-1:0] alu_flags;

   // A lone valid requester always wins; a tie goes to prio.
   always_comb begin
      grant = prio;
      if (req0_valid && !req1_valid) begin
         grant = 1'b0;
      end else if (req1_valid && !req0_valid) begin
         grant = 1'b1;
      end
   end

   assign req0_ready = !rst && (state == IDLE) && !grant && req0_valid;
   assign req1_ready = !rst && (state == IDLE) &&  grant && req1_valid;
   assign accept     = req0_ready || req1_ready;
   assign sel_op     = grant ? req1_op : req0_op;

   alu u_alu (
      .clk   (clk),
      .rst   (rst),
      .a     (a_q),
      .b     (b_q),
      .op    (op_q),
      .out   (alu_out),
      .flags (alu_flags)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         prio      <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= ALU_ADD;
         id_q      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_out   <= '0;
         rsp_flags <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_q   <= grant ? req1_a : req0_a;
                  b_q   <= grant ? req1_b : req0_b;
                  op_q  <= sel_op;
                  id_q  <= grant;
                  cnt   <= (sel_op == ALU_MUL) ? CNT_W'(MUL_LAT) : '0;
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  rsp_out   <= alu_out;
                  rsp_flags <= alu_flags;
                  rsp_id    <= id_q;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               // Alternate priority away from whoever was just served.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  prio      <= ~rsp_id;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized ops against a reference model.
module tb_alu_arbiter;

   localparam int unsigned MUL_LAT = 2;

   logic        clk;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_op, req1_op;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [31:0] rsp_out;
   logic [3:0]  rsp_flags;

   int errors = 0;
   int checks = 0;

   alu_arbiter #(.MUL_LAT(MUL_LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_out    (rsp_out),
      .rsp_flags  (rsp_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: exact wide arithmetic, then wrap; V means the signed result does not fit in 32 bits.
   function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      longint sa, sb, exact;
      logic [63:0] wide;
      logic [31:0] r, d;
      logic c, v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      d  = a - b;
      c  = (d > a);
      v  = 1'b0;
      case (op)
         4'd0: begin
            wide  = 64'(a) + 64'(b);
            r     = wide[31:0];
            c     = (wide >= 64'h1_0000_0000);
            exact = sa + sb;
            v     = (exact != longint'($signed(r)));
         end
         4'd1: begin
            r     = d;
            exact = sa - sb;
            v     = (exact != longint'($signed(r)));
         end
         4'd2: begin
            wide = 64'(a) * 64'(b);
            r    = wide[31:0];
         end
         default: r = 32'd0;
      endcase
      return {r, r[31], (r == 32'd0), c, v};
   endfunction

   // One op from an idle arbiter: handshake, latency, result, hold under back-pressure, release.
   task automatic do_op(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input int bp, output logic [31:0] o, output logic [3:0] f, output logic i,
                        output int lat);
      logic [35:0] e;
      int n;
      bit got;
      e = model(a, b, op);
      if (id) begin
         req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
      end else begin
         req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
      end
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         #1;
         got = id ? req1_ready : req0_ready;
         if (!got) begin
            @(posedge clk); #1;
            n++;
         end
      end
      chk("accept_wait", 64'(n), 64'd0);
      chk("other_ready", 64'(id ? req0_ready : req1_ready), 64'd0);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      n = 1;
      while (!rsp_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      lat = n;
      chk("latency", 64'(n), (op == 4'd2) ? 64'(2 + MUL_LAT) : 64'd2);
      chk("rsp_out", 64'(rsp_out), 64'(e[35:4]));
      chk("rsp_flags", 64'(rsp_flags), 64'(e[3:0]));
      chk("rsp_id", 64'(rsp_id), 64'(id));
      o = rsp_out;
      f = rsp_flags;
      i = rsp_id;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("busy_ready", 64'({req0_ready, req1_ready}), 64'd0);
      for (int k = 0; k < bp; k++) begin
         @(posedge clk); #1;
         chk("bp_valid", 64'(rsp_valid), 64'd1);
         chk("bp_out", 64'({rsp_out, rsp_flags, 3'b000, rsp_id}), 64'({e[35:4], e[3:0], 3'b000, id}));
         chk("bp_ready", 64'({req0_ready, req1_ready}), 64'd0);
      end
      rsp_ready  = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("rsp_drop", 64'(rsp_valid), 64'd0);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 4))
         0: return 32'hFFFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'h0000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] o;
      logic [3:0]  f;
      logic        i;
      int          lat;
      int          n;
      bit          q_g[$];
      bit          q_r[$];
      logic [35:0] e0, e1;

      // Reset with both requesters already valid, then watch round-robin service.
      rst = 1'b1; rsp_ready = 1'b1;
      req0_a = 32'd1;  req0_b = 32'd2; req0_op = 4'd0; req0_valid = 1'b1;
      req1_a = 32'd10; req1_b = 32'd4; req1_op = 4'd1; req1_valid = 1'b1;
      e0 = model(32'd1, 32'd2, 4'd0);
      e1 = model(32'd10, 32'd4, 4'd1);
      #1;
      chk("reset_ready", 64'({req0_ready, req1_ready}), 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("reset_rsp", 64'({rsp_valid, rsp_id, rsp_flags}), 64'd0);
      chk("reset_out", 64'(rsp_out), 64'd0);
      chk("reset_ready2", 64'({req0_ready, req1_ready}), 64'd0);
      rst = 1'b0;
      n = 0;
      while ((q_g.size() < 4 || q_r.size() < 4) && n < 60) begin
         #1;
         if (req0_ready || req1_ready)
            chk("rr_exclusive", 64'(req0_ready && req1_ready), 64'd0);
         if (req0_ready) q_g.push_back(1'b0);
         if (req1_ready) q_g.push_back(1'b1);
         if (rsp_valid) begin
            q_r.push_back(rsp_id);
            chk("rr_out", 64'({rsp_out, rsp_flags}), rsp_id ? 64'(e1) : 64'(e0));
         end
         @(posedge clk); #1;
         n++;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b0;
      chk("rr_grants", 64'(q_g.size()), 64'd4);
      chk("rr_rsps", 64'(q_r.size()), 64'd4);
      for (int k = 0; k < 4 && k < q_g.size(); k++)
         chk("rr_order", 64'(q_g[k]), 64'(k % 2));
      for (int k = 0; k < 4 && k < q_r.size() && k < q_g.size(); k++)
         chk("rr_rsp_id", 64'(q_r[k]), 64'(q_g[k]));

      // Directed operations.
      do_op(1'b0, 32'd5, 32'd7, 4'b0000, 0, o, f, i, lat);
      chk("add_out", 64'(o), 64'd12);
      chk("add_flags", 64'(f), 64'b0000);
      chk("add_id", 64'(i), 64'd0);
      do_op(1'b1, 32'd3, 32'd5, 4'b0001, 0, o, f, i, lat);
      chk("sub_out", 64'(o), 64'hFFFF_FFFE);
      chk("sub_flags", 64'(f), 64'b1010);
      chk("sub_id", 64'(i), 64'd1);
      do_op(1'b0, 32'h0001_0000, 32'h0001_0000, 4'b0010, 0, o, f, i, lat);
      chk("mul_lat", 64'(lat), 64'd4);
      chk("mul_out", 64'(o), 64'd0);
      chk("mul_z", 64'(f[2]), 64'd1);
      do_op(1'b1, 32'h7FFF_FFFF, 32'd1, 4'b0000, 5, o, f, i, lat);
      chk("ovf_flags", 64'(f), 64'b1001);

      // Leave prio pointing at req1, then reset while a multiply has one count left.
      do_op(1'b0, 32'd9, 32'd9, 4'b0001, 0, o, f, i, lat);
      req0_a = 32'd6; req0_b = 32'd7; req0_op = 4'b0010; req0_valid = 1'b1;
      #1;
      chk("mm_ready", 64'(req0_ready), 64'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      req0_a = 32'd20; req0_b = 32'd22; req0_op = 4'b0000; req0_valid = 1'b1;
      req1_a = 32'd1;  req1_b = 32'd1;  req1_op = 4'b0000; req1_valid = 1'b1;
      #1;
      chk("mm_rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("mm_after_valid", 64'(rsp_valid), 64'd0);
      chk("mm_prio", 64'({req0_ready, req1_ready}), 64'b10);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("mm_no_rsp", 64'(rsp_valid), 64'd0);
      @(posedge clk); #1;
      chk("mm_new_rsp", 64'({rsp_valid, rsp_id}), 64'b10);
      chk("mm_new_out", 64'(rsp_out), 64'd42);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;

      // Randomized ops with random back-pressure.
      for (int t = 0; t < 40; t++) begin
         logic [3:0] rop;
         case ($urandom_range(0, 4))
            0: rop = 4'd0;
            1: rop = 4'd1;
            2: rop = 4'd2;
            default: rop = 4'($urandom_range(3, 15));
         endcase
         do_op(1'($urandom_range(0, 1)), pick_operand(), pick_operand(), rop,
               int'($urandom_range(0, 3)), o, f, i, lat);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single `alu` instance between two requesters. Each requester uses a valid/ready handshake, and the block grants them round-robin. It sequences each operation through a fixed-latency execute phase, with a longer phase for multiply. It returns the registered result and N/Z/C/V flags on a response channel that carries the id of the originating requester. Only one operation is in flight at a time.

## Interface
Parameters:
- `MUL_LAT`, default 2: number of extra execute cycles spent when op = 4'b0010 (multiply). Legal range 0–15.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid`, `req1_valid` in 1: requester i presents an operation.
- `req0_ready`, `req1_ready` out 1: requester i's operation is accepted this cycle.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in 32: operands.
- `req0_op`, `req1_op` in 4: ALU opcode. 0000 = add, 0001 = sub, 0010 = mul, any other value gives result 0.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out 1: requester that issued the result.
- `rsp_out` out 32: ALU result.
- `rsp_flags` out 4: {N, Z, C, V}.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - `grant` is combinational.
    - If only one requester is valid, it wins.
    - If both are valid, requester `prio` wins.
  - `reqi_ready` = (state == IDLE) && grant == i && `reqi_valid`.
  - On handshake:
    - Latch a, b, op and id.
    - Load `cnt` = `MUL_LAT` if op = 0010, else 0.
    - Go to EXEC.
- **EXEC**
  - Latched operands drive `alu`.
  - If `cnt` ≠ 0: decrement `cnt`.
  - If `cnt` = 0: register `alu.out` and `{N,Z,C,V}` into the rsp registers, then go to RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_out`, `rsp_flags` and `rsp_id` are held stable until `rsp_ready`.
  - On `rsp_ready`:
    - Go to IDLE.
    - Set `prio` = ~`rsp_id`.
- Flags are taken from `alu` unmodified:
  - C: carry-out for add, (a−b > a) for all other ops.
  - V: signed overflow per the `alu` add/sub rule.
- Arithmetic is 32-bit modulo 2^32. For mul, only the low 32 bits are kept.
- Requests arriving during EXEC or RESP see ready = 0. Requesters must keep valid and their data stable until ready.
- `rsp_ready` is ignored outside RESP.

## Timing
- Handshake at cycle T gives `rsp_valid` = 1 at T+2 for non-mul ops, and at T+2+`MUL_LAT` for mul.
- A response accepted at cycle R lets the next request be accepted at R+1. Best-case throughput is one op per 3 cycles.
- Reset, on any cycle including mid-EXEC or RESP:
  - State goes to IDLE, `cnt` = 0, `prio` = 0.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_out` = 0, `rsp_flags` = 0.
  - Any pending operation is dropped without a response.
  - Ready outputs are 0 during the reset cycle.
- Back-pressure: `rsp_ready` = 0 holds RESP indefinitely. No new grant is made during that time.
- The `alu` `clk`/`rst` ports are tied to `clk`/`rst`. `alu` is purely combinational.

## Structure
- Shared package `alu_pkg` holds:
  - Opcode constants `ALU_ADD`, `ALU_SUB`, `ALU_MUL`.
  - The `alu_op_t` 4-bit typedef.
  - The flag index constants N = 3, Z = 2, C = 1, V = 0.
  - The FSM state enum `arb_state_t`.
- One sub-module, `alu`, instantiated once. There is no other hierarchy.

## Test plan
- **Single add.** req0 sends a = 5, b = 7, op = 0000 at T. Expect:
  - `rsp_valid` at T+2.
  - `rsp_out` = 12, flags = 0000, `rsp_id` = 0.
- **Sub with borrow.** req1 sends a = 3, b = 5, op = 0001. Expect:
  - `rsp_out` = 0xFFFFFFFE.
  - N = 1, Z = 0, C = 1, V = 0, `rsp_id` = 1.
- **Mul latency.** `MUL_LAT` = 2, req0 sends a = 0x10000, b = 0x10000, op = 0010 at T. Expect:
  - `rsp_valid` at T+4.
  - `rsp_out` = 0, Z = 1.
- **Round-robin.** Both requesters hold valid continuously from reset. Expect:
  - Grants in order 0, 1, 0, 1.
  - Each `rsp_id` matches its grant.
  - Ready is never asserted to both requesters in the same cycle.
- **Back-pressure.** Hold `rsp_ready` = 0 for 5 cycles in RESP. Expect:
  - `rsp_*` outputs stable.
  - Both readys = 0.
  - Release gives IDLE the next cycle.
- **Reset mid-mul.** Assert `rst` in EXEC with `cnt` = 1. Expect:
  - No `rsp_valid` is produced.
  - `prio` = 0, so with both requesters valid req0 is granted first after reset.
